regfile_wr_seq: RTL

- Write-side sequencer directly upstream of the VexRiscv register-file RAM (1 write / 1 async-read, no reset on array contents).
- After reset, sweeps every RAM address with a clear value so the RAM never holds X; then passes core writeback through a one-stage registered write port using valid/ready.
- Also muxes the RAM read data: forwards the in-flight write and masks reads while clearing, so the core sees coherent data.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_rd_fwd.sv | 28 ++
 rtl/regfile_wr_seq.sv | 99 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and FSM state encoding for the register-file write sequencer.
package regfile_pkg;

    localparam int REGFILE_ADDR_W = 5;
    localparam int REGFILE_DATA_W = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_rd_fwd.sv
// Read-side mux for one RAM read port: clear masking, write forwarding, then RAM data.
module regfile_rd_fwd
    import regfile_pkg::*;
#(
    parameter int                 ADDR_W    = REGFILE_ADDR_W,
    parameter int                 DATA_W    = REGFILE_DATA_W,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              force_clear,
    input  logic              fwd_en,
    input  logic [ADDR_W-1:0] fwd_addr,
    input  logic [DATA_W-1:0] fwd_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] rd_data
);

    // The registered write has not reached the RAM yet, so it must win over ram_rd_data.
    always_comb begin
        rd_data = ram_rd_data;
        if (force_clear) begin
            rd_data = CLEAR_VAL;
        end else if (fwd_en && (fwd_addr == rd_addr)) begin
            rd_data = fwd_data;
        end
    end

endmodule

// File: rtl/regfile_wr_seq.sv
// Write-side sequencer for the register-file RAM: clear sweep after reset, then a
// registered writeback port. Optional hardwired-x0 behaviour via REGFILE_X0_DISCARD_EN.
module regfile_wr_seq
    import regfile_pkg::*;
#(
    parameter int                 ADDR_W    = REGFILE_ADDR_W,
    parameter int                 DATA_W    = REGFILE_DATA_W,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              ram_wr_en,
    output logic              ram_wr_mask,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              init_done
);

    localparam logic [0:0]        ST_CLEAR  = CLEAR;
    localparam logic [0:0]        ST_RUN    = RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              accept;
    logic              commit;
    logic              rd_clear;

    // Handshake: a request transfers on a cycle where in_valid and in_ready are both high;
    // in_ready is high exactly while in RUN and does not depend on in_valid.
    assign in_ready = (state == ST_RUN);
    assign accept   = in_valid && in_ready;

`ifdef REGFILE_X0_DISCARD_EN
    assign commit   = accept && (in_addr != '0);
    assign rd_clear = (state == ST_CLEAR) || (rd_addr == '0);
`else
    assign commit   = accept;
    assign rd_clear = (state == ST_CLEAR);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_CLEAR;
            cnt       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (state == ST_CLEAR) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt;
            wr_data_q <= CLEAR_VAL;
            cnt       <= cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
                state <= ST_RUN;
            end
        end else begin
            // Address and data hold when idle so the RAM inputs stay quiet.
            wr_en_q <= commit;
            if (commit) begin
                wr_addr_q <= in_addr;
                wr_data_q <= in_data;
            end
        end
    end

    assign ram_wr_en   = wr_en_q;
    assign ram_wr_mask = 1'b1;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_data = wr_data_q;
    assign ram_rd_addr = rd_addr;
    assign init_done   = (state == ST_RUN);

    regfile_rd_fwd #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CLEAR_VAL (CLEAR_VAL)
    ) u_rd_fwd (
        .force_clear (rd_clear),
        .fwd_en      (wr_en_q),
        .fwd_addr    (wr_addr_q),
        .fwd_data    (wr_data_q),
        .rd_addr     (rd_addr),
        .ram_rd_data (ram_rd_data),
        .rd_data     (rd_data)
    );

endmodule
